// File: rtl/ecc_seq_pkg.sv
// Shared definitions for the GF(2^163) ALU sequencer: field width,
// command opcodes and the controller state encoding.
package ecc_seq_pkg;

    localparam int FW = 163;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_SQR = 2'd2;
    localparam logic [1:0] OP_MOV = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        EXEC      = 3'd1,
        MUL_START = 3'd2,
        MUL_WAIT  = 3'd3,
        SQR       = 3'd4
    } state_e;

endpackage

// File: rtl/seq_regfile.sv
// Operand register file for the ALU sequencer. Three combinational read
// ports and two write requests; the sequencer write-back wins over a host
// write to the same address in the same cycle, different addresses both commit.
module seq_regfile
    import ecc_seq_pkg::*;
#(
    parameter int DW    = FW,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          seq_we_i,
    input  logic [AW-1:0] seq_addr_i,
    input  logic [DW-1:0] seq_data_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_data_i,
    input  logic [AW-1:0] rda_addr_i,
    input  logic [AW-1:0] rdb_addr_i,
    input  logic [AW-1:0] rdc_addr_i,
    output logic [DW-1:0] rda_o,
    output logic [DW-1:0] rdb_o,
    output logic [DW-1:0] rdc_o
);

    logic [DW-1:0] mem_q [DEPTH];

    // Per-entry write merge: sequencer result first, host write otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (seq_we_i && (seq_addr_i == AW'(i))) begin
                    mem_q[i] <= seq_data_i;
                end else if (host_we_i && (host_addr_i == AW'(i))) begin
                    mem_q[i] <= host_data_i;
                end
            end
        end
    end

    assign rda_o = mem_q[rda_addr_i];
    assign rdb_o = mem_q[rdb_addr_i];
    assign rdc_o = mem_q[rdc_addr_i];

endmodule

// File: rtl/ecc_alu_sequencer.sv
// Command-driven controller for the GF(2^163) adder/multiplier/squarer.
// Accepts one field op at a time, latches operand copies from the register
// file, sequences the ALU selects and multiplier handshake, and writes the
// result back. SQR with a repeat count supports Itoh-Tsujii inversion runs.
module ecc_alu_sequencer
    import ecc_seq_pkg::*;
#(
    parameter int FW          = 163,
    parameter int NREG        = 8,
    parameter int CNT_W       = 8,
    parameter int MUL_TIMEOUT = 1024,
    localparam int AW         = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_srca,
    input  logic [AW-1:0]    cmd_srcb,
    input  logic [CNT_W-1:0] cmd_cnt,
    output logic             done,
    output logic             err,
    output logic             busy,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [FW-1:0]    wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [FW-1:0]    rd_data,
    output logic [FW-1:0]    alu_a,
    output logic [FW-1:0]    alu_b,
    output logic             alu_ss,
    output logic             alu_st,
    output logic             alu_sy,
    output logic             alu_m_start,
    input  logic [FW-1:0]    alu_y,
    input  logic             alu_m_done
);

    // Timer must be able to hold MUL_TIMEOUT-1.
    localparam int TW = $clog2(MUL_TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic [FW-1:0]    op_a_q, op_a_d;
    logic [FW-1:0]    op_b_q, op_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             seq_we;
    logic [FW-1:0]    seq_data;
    logic [FW-1:0]    rf_a;
    logic [FW-1:0]    rf_b;

    // A repeat count of zero still performs one squaring.
    function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
        return (c == '0) ? CNT_W'(1) : c;
    endfunction

    seq_regfile #(
        .DW    (FW),
        .DEPTH (NREG),
        .AW    (AW)
    ) u_regfile (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .seq_we_i    (seq_we),
        .seq_addr_i  (dst_q),
        .seq_data_i  (seq_data),
        .host_we_i   (wr_en),
        .host_addr_i (wr_addr),
        .host_data_i (wr_data),
        .rda_addr_i  (cmd_srca),
        .rdb_addr_i  (cmd_srcb),
        .rdc_addr_i  (rd_addr),
        .rda_o       (rf_a),
        .rdb_o       (rf_b),
        .rdc_o       (rd_data)
    );

    // Next-state, ALU select decode and write-back request.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        dst_d       = dst_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        cnt_d       = cnt_q;
        timer_d     = timer_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        seq_we      = 1'b0;
        seq_data    = alu_y;
        alu_ss      = 1'b0;
        alu_st      = 1'b0;
        alu_sy      = 1'b0;
        alu_m_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    op_a_d  = rf_a;
                    op_b_d  = rf_b;
                    cnt_d   = clamp_cnt(cmd_cnt);
                    timer_d = '0;
                    case (cmd_op)
                        OP_MUL:  state_d = MUL_START;
                        OP_SQR:  state_d = SQR;
                        default: state_d = EXEC;
                    endcase
                end
            end
            EXEC: begin
                seq_we  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
                if (op_q == OP_MOV) begin
                    seq_data = op_a_q;
                end else begin
                    alu_st = 1'b1;
                end
            end
            MUL_START: begin
                alu_m_start = 1'b1;
                timer_d     = '0;
                state_d     = MUL_WAIT;
            end
            MUL_WAIT: begin
                // A done arriving in the last allowed cycle still counts.
                if (alu_m_done) begin
                    seq_we  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (timer_q == TW'(MUL_TIMEOUT - 1)) begin
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SQR: begin
                alu_ss = 1'b1;
                alu_sy = 1'b1;
                op_a_d = alu_y;
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    seq_we  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state, operand copies and retire flags.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            dst_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign alu_a     = op_a_q;
    assign alu_b     = op_b_q;

endmodule

// File: tb/tb_ecc_alu_sequencer.sv
// Directed bench for ecc_alu_sequencer with a behavioural GF(2^163) ALU.
module tb_ecc_alu_sequencer;
    import ecc_seq_pkg::*;

    localparam int W  = 163;
    localparam int TO = 16;

    logic         clk;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [2:0]   cmd_dst, cmd_srca, cmd_srcb;
    logic [7:0]   cmd_cnt;
    logic         done, err, busy;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic [2:0]   rd_addr;
    logic [W-1:0] rd_data;
    logic [W-1:0] alu_a, alu_b, alu_y;
    logic         alu_ss, alu_st, alu_sy, alu_m_start, alu_m_done;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_mstart = 0;

    ecc_alu_sequencer #(
        .FW(W), .NREG(8), .CNT_W(8), .MUL_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_cnt(cmd_cnt),
        .done(done), .err(err), .busy(busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_ss(alu_ss), .alu_st(alu_st), .alu_sy(alu_sy),
        .alu_m_start(alu_m_start), .alu_y(alu_y), .alu_m_done(alu_m_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial-basis multiply mod x^163 + x^7 + x^6 + x^3 + 1.
    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r, aa;
        r  = '0;
        aa = a;
        for (int i = 0; i < W; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[W-1] ? ((aa << 1) ^ W'(8'hC9)) : (aa << 1);
        end
        return r;
    endfunction

    // Behavioural ALU: multiplier with programmable latency.
    logic         m_busy;
    int           m_left;
    int           m_lat;
    logic         m_en;
    logic         m_force;
    logic [W-1:0] m_prod;

    always @(posedge clk) begin
        if (rst_n) begin
            m_busy <= 1'b0;
            m_left <= 0;
        end else if (alu_m_start) begin
            m_busy <= 1'b1;
            m_left <= m_lat - 1;
            m_prod <= gf_mul(alu_a, alu_b);
        end else if (m_busy && m_left == 0 && m_en) begin
            m_busy <= 1'b0;
        end else if (m_busy && m_left > 0) begin
            m_left <= m_left - 1;
        end
    end

    assign alu_m_done = (m_busy && m_left == 0 && m_en) || m_force;
    assign alu_y = alu_sy ? gf_mul(alu_a, alu_a) : (alu_st ? (alu_a ^ alu_b) : m_prod);

    always @(posedge clk) begin
        if (done) n_done <= n_done + 1;
        if (alu_m_start) n_mstart <= n_mstart + 1;
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic host_wr(input logic [2:0] a, input logic [W-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic host_rd(input logic [2:0] a, output logic [W-1:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    // Issue one command and wait for done; optional host write at cycle hw_cyc
    // relative to the accept cycle (0 = accept cycle, negative = none).
    task automatic run_cmd(input logic [1:0] op, input logic [2:0] dst,
                           input logic [2:0] sa, input logic [2:0] sb, input logic [7:0] cnt,
                           input int hw_cyc, input logic [2:0] hw_addr, input logic [W-1:0] hw_data,
                           output int cyc, output logic err_s, output logic [3:0] sel1);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst;
        cmd_srca = sa; cmd_srcb = sb; cmd_cnt = cnt;
        if (hw_cyc == 0) begin
            wr_en = 1'b1; wr_addr = hw_addr; wr_data = hw_data;
        end
        cyc = 0; err_s = 1'b0; sel1 = '0;
        while (1) begin
            @(negedge clk);
            cyc++;
            cmd_valid = 1'b0;
            wr_en = 1'b0;
            if (cyc == 1) sel1 = {alu_ss, alu_st, alu_sy, alu_m_start};
            if (cyc == hw_cyc) begin
                wr_en = 1'b1; wr_addr = hw_addr; wr_data = hw_data;
            end
            if (done) begin
                err_s = err;
                break;
            end
            if (cyc >= 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL cmd_wait: no done after %0d cycles, done required", cyc);
                break;
            end
        end
        wr_en = 1'b0;
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [2:0]   dst, sa, sb;
        logic [7:0]   cnt;
        logic [W-1:0] va, vb;
        int           lat;
        int           exp_cyc;
        logic [3:0]   exp_sel;   // {ss, st, sy, m_start} in the cycle after accept
        logic [W-1:0] exp_y;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int           cyc;
        logic         e;
        logic [3:0]   s;
        logic [W-1:0] d, acc;
        int           nd0, nm0;

        vecs[0] = '{OP_ADD, 3'd0, 3'd1, 3'd2, 8'd0, W'(5), W'(3), 0, 2, 4'b0100, W'(6)};
        vecs[1] = '{OP_MUL, 3'd3, 3'd1, 3'd2, 8'd0, W'(2), W'(3), 7, 9, 4'b0001, W'(6)};
        vecs[2] = '{OP_SQR, 3'd4, 3'd4, 3'd4, 8'd3, W'(2), W'(0), 0, 4, 4'b1010, W'(256)};
        vecs[3] = '{OP_SQR, 3'd4, 3'd4, 3'd4, 8'd0, W'(2), W'(0), 0, 2, 4'b1010, W'(4)};
        vecs[4] = '{OP_MOV, 3'd6, 3'd1, 3'd1, 8'd0, W'(5), W'(0), 0, 2, 4'b0000, W'(5)};
        vecs[5] = '{OP_ADD, 3'd1, 3'd1, 3'd2, 8'd0, W'(8'hF0), W'(8'h0F), 0, 2, 4'b0100, W'(8'hFF)};
        vecs[6] = '{OP_MUL, 3'd5, 3'd2, 3'd3, 8'd0, W'(8'h10), W'(8'h10), 16, 18, 4'b0001, W'(256)};
        vecs[7] = '{OP_SQR, 3'd7, 3'd7, 3'd7, 8'd1, (W'(1) << 100), W'(0), 0, 2, 4'b1010,
                    W'(48'h1920_0000_0000)};
        vecs[8] = '{OP_MUL, 3'd0, 3'd6, 3'd7, 8'd0, (W'(1) << 100), (W'(1) << 100), 5, 7, 4'b0001,
                    W'(48'h1920_0000_0000)};

        cmd_valid = 0; cmd_op = 0; cmd_dst = 0; cmd_srca = 0; cmd_srcb = 0; cmd_cnt = 0;
        wr_en = 0; wr_addr = 0; wr_data = '0; rd_addr = 0;
        m_lat = 5; m_en = 1'b1; m_force = 1'b0;

        // Reset state
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_ready", W'(cmd_ready), W'(1));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_done_err", W'({done, err}), W'(0));
        chk("rst_selects", W'({alu_ss, alu_st, alu_sy, alu_m_start}), W'(0));
        chk("rst_operands", alu_a | alu_b, W'(0));
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            host_rd(3'(i), d);
            acc = acc | d;
        end
        chk("rst_regfile", acc, W'(0));

        // Table-driven single commands
        for (int i = 0; i < 9; i++) begin
            host_wr(vecs[i].sa, vecs[i].va);
            if (vecs[i].sb != vecs[i].sa) host_wr(vecs[i].sb, vecs[i].vb);
            m_lat = vecs[i].lat;
            nm0 = n_mstart;
            run_cmd(vecs[i].op, vecs[i].dst, vecs[i].sa, vecs[i].sb, vecs[i].cnt,
                    -1, 3'd0, W'(0), cyc, e, s);
            chk($sformatf("v%0d_latency", i), W'(cyc), W'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_err", i), W'(e), W'(0));
            chk($sformatf("v%0d_selects", i), W'(s), W'(vecs[i].exp_sel));
            chk($sformatf("v%0d_mstarts", i), W'(n_mstart - nm0),
                W'((vecs[i].op == OP_MUL) ? 1 : 0));
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), W'({done, cmd_ready}), W'(2'b01));
            host_rd(vecs[i].dst, d);
            chk($sformatf("v%0d_result", i), d, vecs[i].exp_y);
        end

        // Host write to srca in the accept cycle: operand uses the old value
        host_wr(3'd1, W'(5));
        host_wr(3'd2, W'(3));
        run_cmd(OP_ADD, 3'd0, 3'd1, 3'd2, 8'd0, 0, 3'd1, W'(8'hFF), cyc, e, s);
        @(negedge clk);
        host_rd(3'd0, d);
        chk("accept_wr_operand", d, W'(6));
        host_rd(3'd1, d);
        chk("accept_wr_commit", d, W'(8'hFF));

        // Write-back vs host write to the same register: sequencer wins
        host_wr(3'd1, W'(5));
        run_cmd(OP_ADD, 3'd0, 3'd1, 3'd2, 8'd0, 1, 3'd0, W'(16'hDEAD), cyc, e, s);
        @(negedge clk);
        host_rd(3'd0, d);
        chk("conflict_same_addr", d, W'(6));

        // Write-back and host write to different registers both commit
        host_wr(3'd0, W'(0));
        run_cmd(OP_ADD, 3'd0, 3'd1, 3'd2, 8'd0, 1, 3'd5, W'(8'h77), cyc, e, s);
        @(negedge clk);
        host_rd(3'd0, d);
        chk("conflict_diff_dst", d, W'(6));
        host_rd(3'd5, d);
        chk("conflict_diff_host", d, W'(8'h77));

        // Multiplier done while idle is ignored
        nd0 = n_done;
        host_rd(3'd3, acc);
        @(negedge clk);
        m_force = 1'b1;
        @(negedge clk);
        m_force = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_mdone_nodone", W'(n_done - nd0), W'(0));
        chk("idle_mdone_busy", W'(busy), W'(0));
        host_rd(3'd3, d);
        chk("idle_mdone_reg", d, acc);

        // Multiplier timeout: done+err, destination untouched
        host_wr(3'd7, W'(8'hAB));
        m_en = 1'b0;
        nm0 = n_mstart;
        run_cmd(OP_MUL, 3'd7, 3'd1, 3'd2, 8'd0, -1, 3'd0, W'(0), cyc, e, s);
        chk("timeout_latency", W'(cyc), W'(TO + 2));
        chk("timeout_err", W'(e), W'(1));
        chk("timeout_mstarts", W'(n_mstart - nm0), W'(1));
        @(negedge clk);
        chk("timeout_err_pulse", W'({done, err}), W'(0));
        host_rd(3'd7, d);
        chk("timeout_dst", d, W'(8'hAB));

        // Reset in the middle of a multiply
        host_wr(3'd1, W'(2));
        host_wr(3'd2, W'(3));
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_MUL; cmd_dst = 3'd3; cmd_srca = 3'd1; cmd_srcb = 3'd2;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midmul_busy_before", W'(busy), W'(1));
        nd0 = n_done;
        rst_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        m_en = 1'b1;
        @(negedge clk);
        chk("midmul_busy", W'(busy), W'(0));
        chk("midmul_ready", W'(cmd_ready), W'(1));
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            host_rd(3'(i), d);
            acc = acc | d;
        end
        chk("midmul_regs_zero", acc, W'(0));
        repeat (20) @(negedge clk);
        chk("midmul_no_done", W'(n_done - nd0), W'(0));

        host_wr(3'd1, W'(5));
        host_wr(3'd2, W'(3));
        run_cmd(OP_ADD, 3'd0, 3'd1, 3'd2, 8'd0, -1, 3'd0, W'(0), cyc, e, s);
        chk("post_rst_latency", W'(cyc), W'(2));
        @(negedge clk);
        host_rd(3'd0, d);
        chk("post_rst_result", d, W'(6));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, bench end required");
        $fatal(1, "watchdog");
    end

endmodule
